// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, a single-outstanding memory request,
// a one-entry response buffer used under stall, and an IF/ID register feeding decode.
// A taken-branch redirect pre-empts everything. A response that is still in flight
// when a redirect arrives is discarded through the drop flag.
module fetch_stage #(
  parameter int                 ADDR_W   = 8,
  parameter int                 INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [3:0]        if_opcode
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              drop;      // an abandoned response is still in flight
  logic              hold_vld;  // parked response waiting for IF/ID to free up
  fetch_ent_t        hold_q;
  fetch_ent_t        ifid_q;

  // pc + 1 wraps naturally at 2^ADDR_W
  assign pc_inc    = pc + ADDR_W'(1);

  // Request is a pure decode of the state flop, so it is glitch-free
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  assign if_inst   = ifid_q.inst;
  assign if_pc     = ifid_q.pc;
  assign if_opcode = ifid_q.inst[INST_W-1 -: 4];

  // Fetch FSM, PC, response buffer and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      hold_vld <= 1'b0;
      hold_q   <= '0;
      ifid_q   <= '0;
      if_valid <= 1'b0;
    end else if (redirect) begin
      // Redirect overrides stall: flush IF/ID and the buffer, restart at target
      pc       <= redirect_pc;
      if_valid <= 1'b0;
      hold_vld <= 1'b0;
      unique case (state)
        S_REQ: begin
          // A request accepted this very cycle is still outstanding
          if (imem_ready) begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end else begin
            state <= S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            // Response arrives now and is simply thrown away
            state <= S_REQ;
            drop  <= 1'b0;
          end else begin
            // Keep waiting so the stale response is swallowed later
            drop  <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      // Decode takes the IF/ID entry whenever it is not stalling
      if (if_valid && !stall) if_valid <= 1'b0;

      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              // Stale data from before a redirect; pc already points at the target
              drop  <= 1'b0;
              state <= S_REQ;
            end else if (!if_valid || !stall) begin
              ifid_q   <= '{inst: imem_rdata, pc: pc};
              if_valid <= 1'b1;
              pc       <= pc_inc;
              state    <= S_REQ;
            end else begin
              // IF/ID is occupied and held: park the response
              hold_q   <= '{inst: imem_rdata, pc: pc};
              hold_vld <= 1'b1;
              pc       <= pc_inc;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_q   <= hold_q;
            if_valid <= hold_vld;
            hold_vld <= 1'b0;
            state    <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests for fetch_stage. A small instruction memory
// model answers each accepted request after a programmable latency.
// Scenario tasks run back to back and each continues from the state the
// previous one leaves behind; edge numbers in comments count posedges after
// reset release.
module tb_fetch_stage;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [3:0]        if_opcode;

  int total = 0;
  int bad   = 0;

  logic [INST_W-1:0] mem [256];
  int                lat;
  logic              pend;
  int                cnt;
  logic [ADDR_W-1:0] paddr;

  fetch_stage #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_opcode(if_opcode)
  );

  always #5 clk = ~clk;

  // Memory model: notes a handshake on the falling edge before the accepting
  // posedge and presents rdata so it is sampled lat posedges later
  always @(negedge clk) begin
    if (!rst_n) begin
      pend        = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[paddr];
          pend        = 1'b0;
        end
      end
      if (imem_req && imem_ready && !pend) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", if_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    total++; if (if_inst !== 16'h0000) begin bad++; $display("FAIL rst_inst got=%h exp=0000", if_inst); end
    total++; if (if_pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", if_pc); end
    total++; if (if_opcode !== 4'h0) begin bad++; $display("FAIL rst_opcode got=%h exp=0", if_opcode); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    tick(); // E1: IDLE -> REQ
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL fetch_req0 got=%0b/%h exp=1/00", imem_req, imem_addr); end
    tick(); // E2: WAIT
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL fetch_wait0 req=%0b valid=%0b exp=0/0", imem_req, if_valid); end
    tick(); // E3: first instruction lands
    total++; if (if_valid !== 1'b1 || if_inst !== 16'h1234 || if_pc !== 8'h00 || if_opcode !== 4'h1) begin bad++; $display("FAIL fetch_i0 got=%0b/%h/%h/%h exp=1/1234/00/1", if_valid, if_inst, if_pc, if_opcode); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin bad++; $display("FAIL fetch_req1 got=%0b/%h exp=1/01", imem_req, imem_addr); end
    tick(); // E4
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fetch_gap1 got=%0b exp=0", if_valid); end
    tick(); // E5
    total++; if (if_valid !== 1'b1 || if_inst !== 16'h2345 || if_pc !== 8'h01 || if_opcode !== 4'h2) begin bad++; $display("FAIL fetch_i1 got=%0b/%h/%h/%h exp=1/2345/01/2", if_valid, if_inst, if_pc, if_opcode); end
    total++; if (imem_addr !== 8'h02) begin bad++; $display("FAIL fetch_req2 got=%h exp=02", imem_addr); end
    tick(); // E6
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL fetch_gap2 got=%0b exp=0", if_valid); end
    tick(); // E7
    total++; if (if_valid !== 1'b1 || if_inst !== 16'h3456 || if_pc !== 8'h02 || if_opcode !== 4'h3) begin bad++; $display("FAIL fetch_i2 got=%0b/%h/%h/%h exp=1/3456/02/3", if_valid, if_inst, if_pc, if_opcode); end
  endtask

  task automatic test_stall();
    // IF/ID holds pc 2; the request for addr 3 goes out and its data gets parked
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); // E8..E12
      total++; if (if_valid !== 1'b1 || if_inst !== 16'h3456 || if_pc !== 8'h02 || imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%0b/%h/%h req=%0b exp=1/3456/02 req=0", k, if_valid, if_inst, if_pc, imem_req); end
    end
    stall = 1'b0;
    tick(); // E13: buffer moves to IF/ID
    total++; if (if_valid !== 1'b1 || if_inst !== 16'h4567 || if_pc !== 8'h03) begin bad++; $display("FAIL stall_release got=%0b/%h/%h exp=1/4567/03", if_valid, if_inst, if_pc); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin bad++; $display("FAIL stall_nextreq got=%0b/%h exp=1/04", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    tick(); // E14
    tick(); // E15: pc 4 loaded, request addr 5
    total++; if (if_inst !== 16'h5678 || if_pc !== 8'h04 || imem_addr !== 8'h05) begin bad++; $display("FAIL rdw_pre got=%h/%h addr=%h exp=5678/04 addr=05", if_inst, if_pc, imem_addr); end
    lat = 3;
    tick(); // E16: waiting for addr 5
    redirect = 1'b1; redirect_pc = 8'h40;
    tick(); // E17: redirect seen in WAIT without rvalid
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h40) begin bad++; $display("FAIL rdw_flush got=%0b req=%0b addr=%h exp=0 req=0 addr=40", if_valid, imem_req, imem_addr); end
    tick(); // E18: still waiting on the stale response
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rdw_stillwait got=%0b exp=0", imem_req); end
    tick(); // E19: stale response dropped
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || if_valid !== 1'b0) begin bad++; $display("FAIL rdw_refetch got=%0b/%h valid=%0b exp=1/40 valid=0", imem_req, imem_addr, if_valid); end
    total++; if (if_inst === 16'h6789) begin bad++; $display("FAIL rdw_leak got=%h exp=not 6789", if_inst); end
    lat = 1;
    tick(); // E20
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rdw_gap got=%0b exp=0", if_valid); end
    tick(); // E21
    total++; if (if_valid !== 1'b1 || if_inst !== 16'hA0B1 || if_pc !== 8'h40 || if_opcode !== 4'hA) begin bad++; $display("FAIL rdw_target got=%0b/%h/%h/%h exp=1/a0b1/40/a", if_valid, if_inst, if_pc, if_opcode); end
  endtask

  task automatic test_redirect_stall_wrap();
    stall = 1'b1;
    tick(); // E22: WAIT for addr 41
    tick(); // E23: response parked, HOLD
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 8'h40) begin bad++; $display("FAIL rsw_hold req=%0b got=%0b/%h exp=0 1/40", imem_req, if_valid, if_pc); end
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick(); // E24: redirect with stall and full buffer
    redirect = 1'b0; stall = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'hFF) begin bad++; $display("FAIL rsw_flush got=%0b req=%0b addr=%h exp=0 1 ff", if_valid, imem_req, imem_addr); end
    tick(); // E25
    tick(); // E26: fetch at ff, pc wraps
    total++; if (if_valid !== 1'b1 || if_inst !== 16'hBEEF || if_pc !== 8'hFF || if_opcode !== 4'hB) begin bad++; $display("FAIL rsw_ff got=%0b/%h/%h/%h exp=1/beef/ff/b", if_valid, if_inst, if_pc, if_opcode); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL rsw_wrap got=%0b/%h exp=1/00", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    tick(); // E27: WAIT with if_valid held
    total++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rmid_pre got=%0b req=%0b exp=1 0", if_valid, imem_req); end
    rst_n = 1'b0;
    tick(); // E28: reset
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin bad++; $display("FAIL rmid_clear got=%0b req=%0b addr=%h exp=0 0 00", if_valid, imem_req, imem_addr); end
    total++; if (if_inst !== 16'h0000 || if_opcode !== 4'h0) begin bad++; $display("FAIL rmid_inst got=%h/%h exp=0000/0", if_inst, if_opcode); end
    rst_n = 1'b1; stall = 1'b0;
    tick(); // E29
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin bad++; $display("FAIL rmid_req got=%0b/%h exp=1/00", imem_req, imem_addr); end
    tick(); // E30
    tick(); // E31
    total++; if (if_valid !== 1'b1 || if_inst !== 16'h1234 || if_pc !== 8'h00) begin bad++; $display("FAIL rmid_fetch got=%0b/%h/%h exp=1/1234/00", if_valid, if_inst, if_pc); end
  endtask

  task automatic test_redirect_req();
    // Redirect lands in the same cycle the request for addr 1 is accepted
    redirect = 1'b1; redirect_pc = 8'h80;
    tick(); // E32
    redirect = 1'b0;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL rrq_wait req=%0b valid=%0b exp=0 0", imem_req, if_valid); end
    tick(); // E33: stale addr-1 data dropped
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h80 || if_valid !== 1'b0) begin bad++; $display("FAIL rrq_refetch got=%0b/%h valid=%0b exp=1/80 0", imem_req, imem_addr, if_valid); end
    tick(); // E34
    tick(); // E35
    total++; if (if_valid !== 1'b1 || if_inst !== 16'hC0DE || if_pc !== 8'h80) begin bad++; $display("FAIL rrq_target got=%0b/%h/%h exp=1/c0de/80", if_valid, if_inst, if_pc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0F00 | 16'(i);
    mem[8'h00] = 16'h1234; mem[8'h01] = 16'h2345; mem[8'h02] = 16'h3456;
    mem[8'h03] = 16'h4567; mem[8'h04] = 16'h5678; mem[8'h05] = 16'h6789;
    mem[8'h40] = 16'hA0B1; mem[8'h41] = 16'hD00D; mem[8'h80] = 16'hC0DE;
    mem[8'hFF] = 16'hBEEF;
    lat = 1; pend = 1'b0; cnt = 0; paddr = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_stall_wrap();
    test_reset_mid();
    test_redirect_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
